// File: rtl/io_bank_hs.sv
// Bit-addressable I/O bank: synchronised inputs, latched outputs and scratch bits behind a four-phase req/ack handshake.
// Optional IO_BANK_ACCESS_CNT_EN adds a saturating 16-bit count of completed transactions.
module io_bank_hs #(
    parameter int ADDR_WIDTH   = 8,
    parameter int INPUT_SIZE   = 8,
    parameter int OUTPUT_SIZE  = 8,
    parameter int SCRATCH_SIZE = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_i,
    output logic                    ack_o,
    input  logic                    write_i,
    input  logic [ADDR_WIDTH-1:0]   address_i,
    input  logic                    data_i,
    output logic                    data_o,
    input  logic [INPUT_SIZE-1:0]   input_pins,
    output logic [OUTPUT_SIZE-1:0]  output_pins,
    output logic                    err_o
`ifdef IO_BANK_ACCESS_CNT_EN
    ,
    output logic [15:0]             access_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] OUT_BASE = ADDR_WIDTH'(INPUT_SIZE);
    localparam logic [ADDR_WIDTH-1:0] SCR_BASE = ADDR_WIDTH'(INPUT_SIZE + OUTPUT_SIZE);
    localparam logic [ADDR_WIDTH-1:0] SCR_END  = ADDR_WIDTH'(INPUT_SIZE + OUTPUT_SIZE + SCRATCH_SIZE);
    localparam logic [ADDR_WIDTH-1:0] RESERVED = '1;
    localparam logic [OUTPUT_SIZE-1:0]  OUT_ONE = OUTPUT_SIZE'(1);
    localparam logic [SCRATCH_SIZE-1:0] SCR_ONE = SCRATCH_SIZE'(1);

    if (longint'(INPUT_SIZE + OUTPUT_SIZE + SCRATCH_SIZE) >= (longint'(1) << ADDR_WIDTH) - 1) begin : g_bad_map
        $fatal(1, "io_bank_hs: address map does not fit below the reserved all-ones address");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $fatal(1, "io_bank_hs: SYNC_STAGES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

    state_t                   state_q;
    logic                     req_q;
    logic                     wr_q;
    logic                     din_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic                     ack_q;
    logic                     rdata_q;
    logic                     err_q;
    logic [OUTPUT_SIZE-1:0]   output_q;
    logic [SCRATCH_SIZE-1:0]  scratch_q;
    logic [INPUT_SIZE-1:0]    sync_q [SYNC_STAGES];

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q[gi] <= '0;
            end else if (gi == 0) begin
                sync_q[gi] <= input_pins;
            end else begin
                sync_q[gi] <= sync_q[(gi > 0) ? gi - 1 : 0];
            end
        end
    end

    // Decode of the captured address; only consulted in EXEC.
    logic                     read_bit;
    logic                     out_hit;
    logic                     scr_hit;
    logic                     unmapped;
    logic [ADDR_WIDTH-1:0]    out_off;
    logic [ADDR_WIDTH-1:0]    scr_off;
    logic [INPUT_SIZE-1:0]    in_shift;
    logic [OUTPUT_SIZE-1:0]   out_shift;
    logic [SCRATCH_SIZE-1:0]  scr_shift;
    logic [OUTPUT_SIZE-1:0]   output_d;
    logic [SCRATCH_SIZE-1:0]  scratch_d;

    always_comb begin
        out_off   = addr_q - OUT_BASE;
        scr_off   = addr_q - SCR_BASE;
        in_shift  = sync_q[SYNC_STAGES-1] >> addr_q;
        out_shift = output_q >> out_off;
        scr_shift = scratch_q >> scr_off;
        read_bit  = 1'b0;
        out_hit   = 1'b0;
        scr_hit   = 1'b0;
        unmapped  = 1'b0;
        if (addr_q < OUT_BASE) begin
            read_bit = in_shift[0];
        end else if (addr_q < SCR_BASE) begin
            read_bit = out_shift[0];
            out_hit  = 1'b1;
        end else if (addr_q < SCR_END) begin
            read_bit = scr_shift[0];
            scr_hit  = 1'b1;
        end else if (addr_q != RESERVED) begin
            unmapped = 1'b1;
        end
        output_d  = din_q ? (output_q | (OUT_ONE << out_off)) : (output_q & ~(OUT_ONE << out_off));
        scratch_d = din_q ? (scratch_q | (SCR_ONE << scr_off)) : (scratch_q & ~(SCR_ONE << scr_off));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            din_q     <= 1'b0;
            addr_q    <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= 1'b0;
            err_q     <= 1'b0;
            output_q  <= '0;
            scratch_q <= '0;
        end else begin
            req_q <= req_i;
            case (state_q)
                IDLE: begin
                    // Rising edge of req only: a request still held from the last transaction is not new.
                    if (req_i && !req_q) begin
                        wr_q    <= write_i;
                        addr_q  <= address_i;
                        din_q   <= data_i;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rdata_q <= wr_q ? 1'b0 : read_bit;
                    ack_q   <= 1'b1;
                    if (wr_q && out_hit) output_q <= output_d;
                    if (wr_q && scr_hit) scratch_q <= scratch_d;
                    if (unmapped) err_q <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    if (!req_i) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign data_o      = rdata_q;
    assign err_o       = err_q;
    assign output_pins = output_q;

`ifdef IO_BANK_ACCESS_CNT_EN
    logic [15:0] access_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            access_count_q <= '0;
        end else if (state_q == ACK && !req_i && access_count_q != 16'hFFFF) begin
            access_count_q <= access_count_q + 16'd1;
        end
    end

    assign access_count = access_count_q;
`endif

endmodule

// File: tb/tb_io_bank_hs.sv
// Directed bench for io_bank_hs: stimulus queues expected responses, a monitor checks them on each ack_o rise.
module tb_io_bank_hs;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_i = 1'b0;
    logic       ack_o;
    logic       write_i = 1'b0;
    logic [7:0] address_i = 8'd0;
    logic       data_i = 1'b0;
    logic       data_o;
    logic [7:0] input_pins = 8'd0;
    logic [7:0] output_pins;
    logic       err_o;
`ifdef IO_BANK_ACCESS_CNT_EN
    logic [15:0] access_count;
`endif

    io_bank_hs dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .ack_o       (ack_o),
        .write_i     (write_i),
        .address_i   (address_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .input_pins  (input_pins),
        .output_pins (output_pins),
        .err_o       (err_o)
`ifdef IO_BANK_ACCESS_CNT_EN
        ,
        .access_count(access_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       d;
        logic [7:0] out;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // Monitor: pops one expectation per ack_o rising edge and checks latency from req_i rise.
    int   cyc = 0;
    int   req_cyc = 0;
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (req_i && !prev_req) req_cyc = cyc;
        if (ack_o && !prev_ack) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
            end else begin
                e = exp_q.pop_front();
                chk({e.name, ".latency"}, cyc - req_cyc, 2);
                chk({e.name, ".data_o"}, {31'd0, data_o}, {31'd0, e.d});
                chk({e.name, ".output_pins"}, {24'd0, output_pins}, {24'd0, e.out});
                chk({e.name, ".err_o"}, {31'd0, err_o}, {31'd0, e.err});
            end
        end
        prev_req = req_i;
        prev_ack = ack_o;
    end

    task automatic start_req(input string name, input logic w, input logic [7:0] a, input logic d,
                             input logic ed, input logic [7:0] eout, input logic eerr);
        exp_t e;
        e.name = name; e.d = ed; e.out = eout; e.err = eerr;
        @(posedge clk); #2;
        exp_q.push_back(e);
        write_i = w; address_i = a; data_i = d; req_i = 1'b1;
    endtask

    task automatic wait_ack_high(input string name);
        int n = 0;
        while (ack_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (ack_o !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s.ack_timeout: got ack_o=%b, expected 1", name, ack_o);
        end
    endtask

    task automatic finish_req(input string name);
        @(posedge clk); #2;
        req_i = 1'b0;
        @(posedge clk); #1;
        chk({name, ".ack_fall"}, {31'd0, ack_o}, 32'd0);
    endtask

    task automatic txn(input string name, input logic w, input logic [7:0] a, input logic d,
                       input logic ed, input logic [7:0] eout, input logic eerr);
        start_req(name, w, a, d, ed, eout, eerr);
        wait_ack_high(name);
        finish_req(name);
    endtask

    initial begin
        logic [7:0] eo;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.ack_o", {31'd0, ack_o}, 32'd0);
        chk("reset.data_o", {31'd0, data_o}, 32'd0);
        chk("reset.output_pins", {24'd0, output_pins}, 32'd0);
        chk("reset.err_o", {31'd0, err_o}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // 1: write output bit 1, read it back
        txn("wr9", 1'b1, 8'd9, 1'b1, 1'b0, 8'h02, 1'b0);
        txn("rd9", 1'b0, 8'd9, 1'b0, 1'b1, 8'h02, 1'b0);

        // 2: synchronised inputs, write to input ignored
        @(posedge clk); #2;
        input_pins = 8'hA5;
        repeat (2) @(posedge clk);
        txn("rd0", 1'b0, 8'd0, 1'b0, 1'b1, 8'h02, 1'b0);
        txn("rd1", 1'b0, 8'd1, 1'b0, 1'b0, 8'h02, 1'b0);
        txn("rd7", 1'b0, 8'd7, 1'b0, 1'b1, 8'h02, 1'b0);
        txn("wr0", 1'b1, 8'd0, 1'b1, 1'b0, 8'h02, 1'b0);

        // 3: scratch, reserved and unmapped addresses
        txn("wr16", 1'b1, 8'd16, 1'b1, 1'b0, 8'h02, 1'b0);
        txn("wr31", 1'b1, 8'd31, 1'b0, 1'b0, 8'h02, 1'b0);
        txn("wr30", 1'b1, 8'd30, 1'b1, 1'b0, 8'h02, 1'b0);
        txn("rd16", 1'b0, 8'd16, 1'b0, 1'b1, 8'h02, 1'b0);
        txn("rd31", 1'b0, 8'd31, 1'b0, 1'b0, 8'h02, 1'b0);
        txn("rd30", 1'b0, 8'd30, 1'b0, 1'b1, 8'h02, 1'b0);
        txn("rdFF", 1'b0, 8'hFF, 1'b0, 1'b0, 8'h02, 1'b0);
        txn("rd40", 1'b0, 8'd40, 1'b0, 1'b0, 8'h02, 1'b1);
        txn("wrFF", 1'b1, 8'hFF, 1'b1, 1'b0, 8'h02, 1'b1);

        // 4: held request, input changes during ACK ignored
        start_req("hold", 1'b1, 8'd10, 1'b1, 1'b0, 8'h06, 1'b1);
        wait_ack_high("hold");
        address_i = 8'd11;
        data_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold.ack_cyc%0d", i), {31'd0, ack_o}, 32'd1);
        end
        chk("hold.output_pins", {24'd0, output_pins}, 32'h06);
        finish_req("hold");

        // 5: fill outputs, then reset while in ACK
        eo = 8'h06;
        for (int i = 8; i < 16; i++) begin
            eo = eo | (8'h01 << (i - 8));
            txn($sformatf("fill%0d", i), 1'b1, 8'(i), 1'b1, 1'b0, eo, 1'b1);
        end
        start_req("rst_mid", 1'b1, 8'd8, 1'b1, 1'b0, 8'hFF, 1'b1);
        wait_ack_high("rst_mid");
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rst_mid.ack_o", {31'd0, ack_o}, 32'd0);
        chk("rst_mid.output_pins", {24'd0, output_pins}, 32'd0);
        chk("rst_mid.err_o", {31'd0, err_o}, 32'd0);
        chk("rst_mid.data_o", {31'd0, data_o}, 32'd0);
        req_i = 1'b0;
        repeat (2) @(posedge clk); #2;
        reset = 1'b0;
        txn("rd16_after_rst", 1'b0, 8'd16, 1'b0, 1'b0, 8'h00, 1'b0);

`ifdef IO_BANK_ACCESS_CNT_EN
        // 6: counter increments and saturates
        txn("cnt_a", 1'b0, 8'd9, 1'b0, 1'b0, 8'h00, 1'b0);
        txn("cnt_b", 1'b0, 8'd9, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("cnt.three", {16'd0, access_count}, 32'd3);
        @(negedge clk);
        force dut.access_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.access_count_q;
        txn("cnt_c", 1'b0, 8'd9, 1'b0, 1'b0, 8'h00, 1'b0);
        txn("cnt_d", 1'b0, 8'd9, 1'b0, 1'b0, 8'h00, 1'b0);
        txn("cnt_e", 1'b0, 8'd9, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("cnt.saturate", {16'd0, access_count}, 32'hFFFF);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard.empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
